// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and RUN/HALTED control.
// Define FETCH_PERF_CNT_EN to add the saturating fetch_count output.
module fetch_stage (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    output logic [15:0] ifid_instr,
    output logic [15:0] ifid_pc_plus2,
    output logic        ifid_valid,
`ifdef FETCH_PERF_CNT_EN
    output logic        halted,
    output logic [15:0] fetch_count
`else
    output logic        halted
`endif
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetchState_e;

    fetchState_e state;
    fetchState_e stateNext;

    logic [15:0] pc;
    logic [15:0] pcNext;
    logic [15:0] pcPlus2;
    logic [15:0] instrNext;
    logic [15:0] pcPlus2Next;
    logic        validNext;
    logic        isHalt;
`ifdef FETCH_PERF_CNT_EN
    logic        fetchEdge;
`endif

    // Plain 16-bit add: 0xFFFE + 2 wraps to 0x0000 silently.
    assign pcPlus2   = pc + 16'd2;
    assign imem_addr = pc;
    assign isHalt    = (imem_data[15:12] == 4'b1111);

    // Priority: branch redirect, then stall, then HALTED idling, then fetch/halt detect.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        stateNext   = state;
        pcNext      = pc;
        instrNext   = ifid_instr;
        pcPlus2Next = ifid_pc_plus2;
        validNext   = ifid_valid;
`ifdef FETCH_PERF_CNT_EN
        fetchEdge   = 1'b0;
`endif
        if (branch_taken) begin
            pcNext    = {branch_target[15:1], 1'b0};
            instrNext = 16'h0000;
            validNext = 1'b0;
            stateNext = RUN;
        end else if (stall) begin
            stateNext = state;
        end else if (state == HALTED) begin
            instrNext = 16'h0000;
            validNext = 1'b0;
        end else begin
            instrNext   = imem_data;
            pcPlus2Next = pcPlus2;
            validNext   = 1'b1;
`ifdef FETCH_PERF_CNT_EN
            fetchEdge   = 1'b1;
`endif
            // HLT is still delivered to decode, but the PC parks on it.
            if (isHalt) begin
                stateNext = HALTED;
            end else begin
                pcNext = pcPlus2;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc            <= 16'h0000;
            ifid_instr    <= 16'h0000;
            ifid_pc_plus2 <= 16'h0000;
            ifid_valid    <= 1'b0;
            halted        <= 1'b0;
        end else begin
            pc            <= pcNext;
            ifid_instr    <= instrNext;
            ifid_pc_plus2 <= pcPlus2Next;
            ifid_valid    <= validNext;
            halted        <= (stateNext == HALTED);
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count <= 16'h0000;
        end else if (fetchEdge && (fetch_count != 16'hFFFF)) begin
            fetch_count <= fetch_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a transaction-level fetch model pushes the expected
// IF/ID contents per clock edge; a negedge monitor pops and compares.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_target = 16'h0000;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc_plus2;
    logic        ifid_valid;
    logic        halted;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fetch_count;
`endif

    fetch_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .ifid_instr    (ifid_instr),
        .ifid_pc_plus2 (ifid_pc_plus2),
        .ifid_valid    (ifid_valid),
        .halted        (halted)
`ifdef FETCH_PERF_CNT_EN
        , .fetch_count (fetch_count)
`endif
    );

    always #5 clk = ~clk;

    // Word-addressed instruction memory, read combinationally.
    logic [15:0] mem [0:32767];
    assign imem_data = mem[imem_addr[15:1]];

    typedef struct {
        logic [15:0] pc;
        logic [15:0] instr;
        logic [15:0] pc2;
        logic        valid;
        logic        halted;
        logic [15:0] count;
    } expect_t;

    expect_t expQ[$];
    expect_t monExp;

    // Reference model: architectural view of the fetch unit.
    logic [15:0] mPc;
    logic [15:0] mInstr;
    logic [15:0] mPc2;
    logic        mValid;
    logic        mHalted;
    int          mCount;

    int nChecks = 0;
    int nFails  = 0;

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && expQ.size() > 0) begin
            monExp = expQ.pop_front();
            check16("imem_addr", imem_addr, monExp.pc);
            check16("ifid_instr", ifid_instr, monExp.instr);
            check16("ifid_pc_plus2", ifid_pc_plus2, monExp.pc2);
            check1("ifid_valid", ifid_valid, monExp.valid);
            check1("halted", halted, monExp.halted);
`ifdef FETCH_PERF_CNT_EN
            check16("fetch_count", fetch_count, monExp.count);
`endif
        end
    end

    // Drive one cycle's inputs, advance the model across the coming edge, queue the result.
    task automatic step(input logic s, input logic b, input logic [15:0] t);
        expect_t     e;
        logic [15:0] w;
        stall         = s;
        branch_taken  = b;
        branch_target = t;
        if (b) begin
            mPc     = {t[15:1], 1'b0};
            mInstr  = 16'h0000;
            mValid  = 1'b0;
            mHalted = 1'b0;
        end else if (s) begin
            mValid = mValid;
        end else if (mHalted) begin
            mInstr = 16'h0000;
            mValid = 1'b0;
        end else begin
            w      = mem[mPc[15:1]];
            mInstr = w;
            mPc2   = mPc + 16'd2;
            mValid = 1'b1;
            if (mCount < 65535) mCount++;
            if (w[15:12] == 4'hF) mHalted = 1'b1;
            else mPc = mPc + 16'd2;
        end
        e.pc     = mPc;
        e.instr  = mInstr;
        e.pc2    = mPc2;
        e.valid  = mValid;
        e.halted = mHalted;
        e.count  = 16'(mCount);
        @(posedge clk);
        expQ.push_back(e);
        #1;
    endtask

    // Asynchronous reset between edges; checks outputs before any clock edge arrives.
    task automatic applyReset();
        @(negedge clk);
        #1;
        rst_n        = 1'b0;
        stall        = 1'b0;
        branch_taken = 1'b0;
        #1;
        check16("rst imem_addr", imem_addr, 16'h0000);
        check16("rst ifid_instr", ifid_instr, 16'h0000);
        check16("rst ifid_pc_plus2", ifid_pc_plus2, 16'h0000);
        check1("rst ifid_valid", ifid_valid, 1'b0);
        check1("rst halted", halted, 1'b0);
`ifdef FETCH_PERF_CNT_EN
        check16("rst fetch_count", fetch_count, 16'h0000);
`endif
        expQ.delete();
        mPc     = 16'h0000;
        mInstr  = 16'h0000;
        mPc2    = 16'h0000;
        mValid  = 1'b0;
        mHalted = 1'b0;
        mCount  = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
        mem[16'h0000 >> 1] = 16'h1234;
        mem[16'h0002 >> 1] = 16'h2345;
        mem[16'h0004 >> 1] = 16'h3456;
        mem[16'h0010 >> 1] = 16'h1111;
        mem[16'h0012 >> 1] = 16'h2222;
        mem[16'h0040 >> 1] = 16'h4040;
        mem[16'h0030 >> 1] = 16'hF000;
        mem[16'h0100 >> 1] = 16'h5A5A;
        mem[16'hFFFE >> 1] = 16'h7777;

        applyReset();

        // Two fetches straight out of reset.
        step(1'b0, 1'b0, 16'h0000);
        check16("edge1 instr", ifid_instr, 16'h1234);
        check16("edge1 pc_plus2", ifid_pc_plus2, 16'h0002);
        check1("edge1 valid", ifid_valid, 1'b1);
        step(1'b0, 1'b0, 16'h0000);
        check16("edge2 instr", ifid_instr, 16'h2345);
        check16("edge2 pc_plus2", ifid_pc_plus2, 16'h0004);

        // Stall for three cycles at 0x0010, then resume.
        step(1'b0, 1'b1, 16'h0010);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 16'h0000);
            check16("stall pc", imem_addr, 16'h0010);
            check1("stall valid", ifid_valid, 1'b0);
        end
        step(1'b0, 1'b0, 16'h0000);
        check16("post-stall instr", ifid_instr, 16'h1111);
        check16("post-stall pc_plus2", ifid_pc_plus2, 16'h0012);

        // Branch from 0x0020 to odd target 0x0041: one bubble, then 0x0040.
        step(1'b0, 1'b1, 16'h0020);
        step(1'b0, 1'b1, 16'h0041);
        check16("branch pc", imem_addr, 16'h0040);
        check1("branch bubble valid", ifid_valid, 1'b0);
        check16("branch bubble instr", ifid_instr, 16'h0000);
        step(1'b0, 1'b0, 16'h0000);
        check16("branch target instr", ifid_instr, 16'h4040);
        check1("branch target valid", ifid_valid, 1'b1);

        // HLT at 0x0030.
        step(1'b0, 1'b1, 16'h0030);
        step(1'b0, 1'b0, 16'h0000);
        check16("hlt instr", ifid_instr, 16'hF000);
        check1("hlt valid", ifid_valid, 1'b1);
        check16("hlt pc", imem_addr, 16'h0030);
        check1("hlt halted", halted, 1'b1);
        step(1'b0, 1'b0, 16'h0000);
        check1("halted bubble", ifid_valid, 1'b0);
        step(1'b0, 1'b0, 16'h0000);

        // Branch out of HALTED.
        step(1'b0, 1'b1, 16'h0100);
        check1("unhalt halted", halted, 1'b0);
        check16("unhalt pc", imem_addr, 16'h0100);
        step(1'b0, 1'b0, 16'h0000);
        check16("unhalt fetch", ifid_instr, 16'h5A5A);

        // Reset while halted, then the first fetch comes from 0x0000 again.
        step(1'b0, 1'b1, 16'h0030);
        step(1'b0, 1'b0, 16'h0000);
        applyReset();
        step(1'b0, 1'b0, 16'h0000);
        check16("post-reset instr", ifid_instr, 16'h1234);

        // PC wrap.
        step(1'b0, 1'b1, 16'hFFFE);
        step(1'b0, 1'b0, 16'h0000);
        check16("wrap pc", imem_addr, 16'h0000);
        check16("wrap pc_plus2", ifid_pc_plus2, 16'h0000);
        check16("wrap instr", ifid_instr, 16'h7777);

`ifdef FETCH_PERF_CNT_EN
        // 5 fetches, 2 stalls, 1 branch bubble.
        applyReset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0000);
        step(1'b1, 1'b0, 16'h0000);
        step(1'b1, 1'b0, 16'h0000);
        step(1'b0, 1'b1, 16'h0010);
        step(1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 16'h0000);
        check16("perf count", fetch_count, 16'd5);
        applyReset();
`endif

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                applyReset();
            end else begin
                step($urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0, 16'($urandom));
            end
        end

        stall        = 1'b0;
        branch_taken = 1'b0;
        @(negedge clk);
        #1;
        check16("scoreboard drained", 16'(expQ.size()), 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock.
REQ-002 SHALL have ports: rst_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: imem_addr  out  16  instruction memory address, combinational copy of PC.
REQ-004 SHALL have ports: imem_data  in  16  instruction word at imem_addr, same-cycle, combinational read.
REQ-005 SHALL have ports: stall  in  1  hold PC and IF/ID, from the decode hazard logic.
REQ-006 SHALL have ports: branch_taken  in  1  redirect request, resolved in decode.
REQ-007 SHALL have ports: branch_target  in  16  redirect address.
REQ-008 SHALL have ports: ifid_instr  out  16  registered instruction fed to the decoder.
REQ-009 SHALL have ports: ifid_pc_plus2  out  16  registered PC+2 of ifid_instr, used for B offset and PCS.
REQ-010 SHALL have ports: ifid_valid  out  1  ifid_instr is a real instruction, not a bubble.
REQ-011 SHALL have ports: halted  out  1  high while the FSM is in HALTED.
REQ-012 SHALL use a single clock, clk, and an asynchronous, active-low reset, rst_n.

Function
REQ-013 SHALL hold a 16-bit PC with pc[0] always 0 and drive imem_addr = pc.
REQ-014 SHALL implement a 2-state FSM with states RUN and HALTED.
REQ-015 SHALL apply per-cycle priority in this order: reset, branch_taken, stall, halt detect, normal fetch.
REQ-016 Normal fetch (RUN): pc <= pc+2; ifid_instr <= imem_data; ifid_pc_plus2 <= pc+2; ifid_valid <= 1.
REQ-017 PC+2 SHALL wrap modulo 2^16 (0xFFFE -> 0x0000) with no error indication.
REQ-018 branch_taken SHALL load pc <= {branch_target[15:1],1'b0}, set ifid_valid <= 0 and ifid_instr <= 16'h0000, and force the FSM to RUN, including from HALTED and regardless of stall.
REQ-019 stall without branch_taken SHALL hold pc, ifid_instr, ifid_pc_plus2, ifid_valid and the FSM state unchanged.
REQ-020 Halt detect: in RUN with imem_data[15:12]==4'b1111 and no branch/stall, IF/ID SHALL latch HLT as in REQ-016, pc SHALL NOT advance, and the FSM SHALL go to HALTED.
REQ-021 In HALTED without branch_taken: pc held, ifid_valid <= 0, ifid_instr <= 16'h0000, ifid_pc_plus2 held, imem_data ignored.
REQ-022 Branch latency: the instruction at branch_target SHALL appear in ifid_instr, valid, on the second rising edge after branch_taken is sampled, with exactly one bubble in between.
REQ-023 halted SHALL be a registered output equal to (state==HALTED).

Reset
REQ-024 On rst_n low, asynchronously: pc=0x0000, ifid_instr=0x0000, ifid_pc_plus2=0x0000, ifid_valid=0, state=RUN, halted=0.
REQ-025 Reset asserted mid-operation, including in HALTED or during stall, SHALL abandon all state; the first fetch after release SHALL be from 0x0000.
REQ-026 The first rising edge after rst_n deassertion SHALL perform a normal fetch of address 0x0000.

Configuration
REQ-027 Macro FETCH_PERF_CNT_EN, when defined, SHALL add output fetch_count (out, 16) counting edges where ifid_valid is loaded with 1; it resets to 0, saturates at 0xFFFF, and holds during stall and HALTED.
REQ-028 Without FETCH_PERF_CNT_EN, the fetch_count port and counter logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-029 Reset release, imem returns 0x1234 @0x0000 and 0x2345 @0x0002 -> after edge 1: ifid_instr=0x1234, ifid_pc_plus2=0x0002, valid=1; after edge 2: 0x2345, 0x0004.
REQ-030 stall high for 3 cycles at pc=0x0010 -> pc, ifid_* and state unchanged for 3 edges; resumes at 0x0010 after stall drops.
REQ-031 branch_taken=1, target=0x0041 at pc=0x0020 -> pc=0x0040, valid=0, instr=0x0000 next edge; instr from 0x0040 valid on the following edge.
REQ-032 imem_data=0xF000 @0x0030 -> ifid_instr=0xF000 valid, pc stays 0x0030, halted=1; subsequent cycles valid=0.
REQ-033 In HALTED, branch_taken with target 0x0100 -> halted=0, pc=0x0100, normal fetch resumes; separately, pc=0xFFFE normal fetch -> pc=0x0000, ifid_pc_plus2=0x0000.
REQ-034 With FETCH_PERF_CNT_EN: 5 fetches, 2 stalls, 1 branch bubble -> fetch_count=5; rst_n low -> fetch_count=0.
